// File: rtl/pll_drp_pkg.sv
// Shared types for the PLL DRP reconfiguration sequencer: FSM states,
// table entry layout and the read-modify-write merge.
package pll_drp_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_RD,
        S_WGAP,
        S_WR,
        S_RELEASE,
        S_LOCK,
        S_FINISH
    } state_t;

    typedef struct packed {
        logic [DRP_AW-1:0] addr;
        logic [DRP_DW-1:0] mask;
        logic [DRP_DW-1:0] data;
    } entry_t;

    // Mask bits set keep the register's current value; clear bits take entry data.
    function automatic logic [DRP_DW-1:0] rmw_merge(input logic [DRP_DW-1:0] old_val,
                                                    input entry_t e);
        return (old_val & e.mask) | (e.data & ~e.mask);
    endfunction

endpackage

// File: rtl/pll_drp_rmw_port.sv
// One DRP phase handshake: completion requires drp_done seen low (stale latch
// cleared) and then high again, with a cycle-count timeout.
module pll_drp_rmw_port #(
    parameter int TMO = 1023,
    parameter int TW  = 16
) (
    input  logic drp_clk,
    input  logic rst_n,
    input  logic run,
    input  logic drp_done,
    output logic ok,
    output logic tmo
);

    logic [TW-1:0] timer;
    logic          seen_low;

    always_ff @(posedge drp_clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= '0;
            seen_low <= 1'b0;
        end else if (!run) begin
            timer    <= '0;
            seen_low <= 1'b0;
        end else begin
            timer <= timer + TW'(1);
            if (!drp_done)
                seen_low <= 1'b1;
        end
    end

    assign ok  = run && seen_low && drp_done;
    assign tmo = run && (timer == TW'(TMO - 1));

endmodule

// File: rtl/pll_drp_sequencer.sv
// Applies a host-loaded table of read-modify-write DRP entries to the PLL
// while holding it in reset, then releases reset and waits for lock.
module pll_drp_sequencer
    import pll_drp_pkg::*;
#(
    parameter int NENT     = 8,
    parameter int AW       = 3,
    parameter int DRP_TMO  = 1023,
    parameter int LOCK_TMO = 65535,
    parameter int TW       = 16
) (
    input  logic              drp_clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_idx,
    input  logic [DRP_AW-1:0] cfg_addr,
    input  logic [DRP_DW-1:0] cfg_mask,
    input  logic [DRP_DW-1:0] cfg_data,
    input  logic [AW:0]       cfg_count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_drp,
    output logic              err_lock,
    output logic              pll_rst,
    input  logic              pll_locked,
    output logic              drp_go,
    output logic              drp_write,
    output logic [DRP_AW-1:0] drp_addr,
    output logic [DRP_DW-1:0] drp_di,
    input  logic              drp_done,
    input  logic [DRP_DW-1:0] drp_do
);

    state_t        state;
    entry_t        entries [NENT];
    entry_t        cur;
    logic [AW:0]   idx;
    logic [AW:0]   count;
    logic [TW-1:0] lock_tmr;
    logic [1:0]    lock_sync;
    logic          accept_start;
    logic          port_run;
    logic          port_ok;
    logic          port_tmo;

    assign accept_start = start && (state == S_IDLE);
    assign cur          = entries[idx[AW-1:0]];
    assign port_run     = (state == S_RD) || (state == S_WR);

    always_ff @(posedge drp_clk) begin
        if (cfg_we && !busy && !accept_start)
            entries[cfg_idx] <= '{addr: cfg_addr, mask: cfg_mask, data: cfg_data};
    end

    // Held clear while the PLL is in reset so a lock left over from the
    // previous configuration cannot end the next sequence early.
    always_ff @(posedge drp_clk or negedge rst_n) begin
        if (!rst_n)
            lock_sync <= 2'b00;
        else if (pll_rst)
            lock_sync <= 2'b00;
        else
            lock_sync <= {lock_sync[0], pll_locked};
    end

    pll_drp_rmw_port #(
        .TMO (DRP_TMO),
        .TW  (TW)
    ) u_port (
        .drp_clk  (drp_clk),
        .rst_n    (rst_n),
        .run      (port_run),
        .drp_done (drp_done),
        .ok       (port_ok),
        .tmo      (port_tmo)
    );

    always_ff @(posedge drp_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            count     <= '0;
            lock_tmr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_drp   <= 1'b0;
            err_lock  <= 1'b0;
            pll_rst   <= 1'b0;
            drp_go    <= 1'b0;
            drp_write <= 1'b0;
            drp_addr  <= '0;
            drp_di    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        count    <= cfg_count;
                        idx      <= '0;
                        err_drp  <= 1'b0;
                        err_lock <= 1'b0;
                        busy     <= 1'b1;
                        pll_rst  <= 1'b1;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (idx < count) begin
                        drp_addr  <= cur.addr;
                        drp_write <= 1'b0;
                        drp_go    <= 1'b1;
                        state     <= S_RD;
                    end else begin
                        state <= S_RELEASE;
                    end
                end
                S_RD: begin
                    if (port_ok) begin
                        drp_di <= rmw_merge(drp_do, cur);
                        drp_go <= 1'b0;
                        state  <= S_WGAP;
                    end else if (port_tmo) begin
                        err_drp   <= 1'b1;
                        drp_go    <= 1'b0;
                        drp_write <= 1'b0;
                        state     <= S_RELEASE;
                    end
                end
                S_WGAP: begin
                    drp_write <= 1'b1;
                    drp_go    <= 1'b1;
                    state     <= S_WR;
                end
                S_WR: begin
                    if (port_ok) begin
                        idx       <= idx + (AW+1)'(1);
                        drp_go    <= 1'b0;
                        drp_write <= 1'b0;
                        state     <= S_GAP;
                    end else if (port_tmo) begin
                        err_drp   <= 1'b1;
                        drp_go    <= 1'b0;
                        drp_write <= 1'b0;
                        state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    pll_rst  <= 1'b0;
                    lock_tmr <= '0;
                    state    <= S_LOCK;
                end
                S_LOCK: begin
                    if (lock_sync[1]) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_FINISH;
                    end else if (lock_tmr == TW'(LOCK_TMO - 1)) begin
                        err_lock <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_FINISH;
                    end else begin
                        lock_tmr <= lock_tmr + TW'(1);
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pll_drp_sequencer.md
Name: pll_drp_sequencer

Overview:
- Sequences dynamic reconfiguration of the PLL wrapper through its DRP port: pll_drp_level interface, i.e. drp_go level, drp_done latch, drp_data_out latch.
- Holds a host-loaded table of up to NENT read-modify-write entries. On start: asserts PLL reset, applies every entry, releases reset, waits for lock.
- Sits in the drp_clk domain between the host register bank and the PLL instance.

Parameters:
NENT, 8, table depth (entries)
AW, 3, table index width, log2(NENT)
DRP_TMO, 1023, max drp_clk cycles per DRP phase before error
LOCK_TMO, 65535, max drp_clk cycles waiting for lock after reset release
TW, 16, timeout counter width; must hold max(DRP_TMO, LOCK_TMO)

Ports:
drp_clk  in  1  sole clock (also drives the PLL DRP clock)
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe, ignored while busy
cfg_idx  in  AW  table write index
cfg_addr  in  7  DRP register address for entry
cfg_mask  in  16  bits set = keep the old register bit
cfg_data  in  16  new bits, used where mask=0
cfg_count  in  AW+1  entries to apply, 0..NENT; sampled on start
start  in  1  one-cycle request, ignored while busy
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end, success or error
err_drp  out  1  sticky: DRP phase timeout; cleared on next accepted start
err_lock  out  1  sticky: lock timeout; cleared on next accepted start
pll_rst  out  1  to PLL rst
pll_locked  in  1  PLL locked, asynchronous; 2-FF synchronized internally
drp_go  out  1  to PLL drp_go (level; PLL edge-detects it)
drp_write  out  1  to PLL drp_write
drp_addr  out  7  to PLL drp_addr
drp_di  out  16  to PLL drp_data_in
drp_done  in  1  from PLL drp_done (latched, cleared 2 cycles after go rises)
drp_do  in  16  from PLL drp_data_out, valid when drp_done=1

Behaviour:
- Reset values: busy=0, done=0, err_drp=0, err_lock=0, pll_rst=0, drp_go=0, drp_write=0, drp_addr=0, drp_di=0. Table contents are not reset.
- Table: NENT x 39-bit registers. Written on cfg_we when not busy. A cfg_we in the same cycle as an accepted start is dropped.
- States and transitions:
  - IDLE: on start, latch cfg_count, idx=0, clear err flags, busy=1, pll_rst=1, go to GAP.
  - GAP: drp_go=0 for exactly one cycle so the PLL sees a rising edge. Next state is RD if idx<count, else RELEASE. count=0 skips straight to RELEASE.
  - RD: drp_addr=entry.addr, drp_write=0, drp_go=1, timer cleared. Wait for drp_done=0 (stale latch cleared), then for drp_done=1. Then capture new = (drp_do & mask) | (data & ~mask) into drp_di, drop go, go to WGAP.
  - WGAP: one cycle with go=0, then WR.
  - WR: drp_write=1, drp_go=1. Same clear-then-set wait on drp_done. Then idx++, go=0, write=0, go to GAP.
  - RELEASE: pll_rst=0, timer cleared, go to LOCK.
  - LOCK: wait for synchronized locked=1, then FINISH.
  - FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Timeouts:
  - Timer counts every cycle in RD, WR and LOCK.
  - RD/WR reaching DRP_TMO: set err_drp, drop go and write, go to RELEASE. Remaining entries are abandoned; pll_rst must never stay stuck high.
  - LOCK reaching LOCK_TMO: set err_lock, go to FINISH.
- drp_addr and drp_write stay stable while drp_go=1.
- Async reset mid-sequence: everything returns to reset values immediately and pll_rst drops.
- Latency with an ideal PLL (done 2 cycles after enable): 1 + per-entry (1+4+1+4) + 1 + lock time + 1 cycles.

Decomposition:
- Package pll_drp_pkg holds:
  - state enum
  - entry typedef {addr[6:0], mask[15:0], data[15:0]}
  - DRP address width 7 and data width 16 constants
- One natural sub-module, pll_drp_rmw_port: the go/done clear-then-set handshake with timeout, reused for read and write phases.

Test Plan:
- One entry {addr=0x08, mask=0xF000, data=0x0145}, PLL model returns 0xA3C2 -> one read of 0x08, then a write of 0xA145. pll_rst high throughout, drops afterwards. After locked rises, done pulses once and busy falls.
- count=3, addresses 0x08/0x09/0x14 -> exactly 3 read/write pairs in table order. drp_go has ≥1 low cycle between phases, and addr/write never change while go=1.
- drp_done held high from before start (stale) -> no phase completes until done has been seen low then high again.
- PLL model never returns done -> after DRP_TMO cycles err_drp=1 and pll_rst released. The next start clears err_drp.
- pll_locked held low with LOCK_TMO=100 -> err_lock=1 and done pulse 100 cycles after release. A start and a cfg_we during busy are ignored.
- rst_n asserted mid-WR -> all outputs return to reset values in the same cycle. A new start after reset runs normally.
